// File: rtl/psram_pkg.sv
// Shared opcodes and FSM state encoding for the QPI PSRAM target model.
package psram_pkg;

    localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
    localparam logic [7:0] CMD_QPI_WRITE = 8'h38;
    localparam logic [7:0] CMD_QPI_READ  = 8'hEB;
    localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StSpiCmd = 4'd1,
        StQpiCmd = 4'd2,
        StAddr   = 4'd3,
        StWait   = 4'd4,
        StRdData = 4'd5,
        StWrData = 4'd6,
        StIgnore = 4'd7
    } psram_target_state_t;

endpackage

// File: rtl/psram_qpi_target_if.sv
// Chip-side PSRAM pins; master is the controller, slave is the device model.
interface psram_qpi_target_if;

    logic       i_psram_csn;
    logic       i_psram_sclk;
    logic [3:0] i_psram_dq;
    logic [3:0] o_psram_dq;
    logic       o_psram_oe;

    modport master (
        output i_psram_csn,
        output i_psram_sclk,
        output i_psram_dq,
        input  o_psram_dq,
        input  o_psram_oe
    );

    modport slave (
        input  i_psram_csn,
        input  i_psram_sclk,
        input  i_psram_dq,
        output o_psram_dq,
        output o_psram_oe
    );

endinterface

// File: rtl/psram_sync.sv
// Two-flop synchronizer with a configurable reset value.
module psram_sync #(
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/psram_qpi_target.sv
// Oversampled QPI PSRAM device model: SPI 35h entry, QPI 38h/EBh/F5h, internal byte array.
module psram_qpi_target
    import psram_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_CYCLES = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    psram_qpi_target_if.slave  bus,
    output logic               o_qpi_mode,
    output logic [3:0]         o_state
);

    localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

    logic                 w_csn, w_sclk, w_sclk_rise, w_sclk_fall;
    logic [3:0]           w_dq;
    logic                 r_sclk_d;

    psram_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_csn (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(bus.i_psram_csn), .o_q(w_csn));
    psram_sync #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(bus.i_psram_sclk), .o_q(w_sclk));
    psram_sync #(.WIDTH(4), .RESET_VAL(4'h0)) u_sync_dq (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(bus.i_psram_dq), .o_q(w_dq));

    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;

    psram_target_state_t  r_state, w_state_nxt;
    logic [3:0]           r_cnt, w_cnt_nxt;
    logic [6:0]           r_shift, w_shift_nxt;
    logic [7:0]           r_cmd, w_cmd_nxt;
    logic [ADDR_BITS-1:0] r_addr, w_addr_nxt, w_addr_shift, w_addr_inc;
    logic                 r_qpi, w_qpi_nxt;
    logic                 r_oe, w_oe_nxt;
    logic [3:0]           r_dq, w_dq_nxt;
    logic                 r_phase, w_phase_nxt;
    logic [3:0]           r_hold, w_hold_nxt;
    logic                 w_rd_en, w_wr_en;
    logic [ADDR_BITS-1:0] w_rd_addr;
    logic [7:0]           r_rdata;
    logic [7:0]           r_mem [DEPTH];

    // Upper address nibbles fall off the top, so only the low ADDR_BITS survive.
    assign w_addr_shift = ADDR_BITS'({r_addr, w_dq});
    assign w_addr_inc   = r_addr + ADDR_BITS'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_cmd_nxt   = r_cmd;
        w_addr_nxt  = r_addr;
        w_qpi_nxt   = r_qpi;
        w_oe_nxt    = r_oe;
        w_dq_nxt    = r_dq;
        w_phase_nxt = r_phase;
        w_hold_nxt  = r_hold;
        w_rd_en     = 1'b0;
        w_rd_addr   = r_addr;
        w_wr_en     = 1'b0;
        if (w_csn) begin
            // Deselect beats any same-cycle sclk edge and drops partial bytes.
            w_state_nxt = StIdle;
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_cnt_nxt   = '0;
                    w_phase_nxt = 1'b0;
                    w_state_nxt = r_qpi ? StQpiCmd : StSpiCmd;
                end
                StSpiCmd: if (w_sclk_rise) begin
                    w_shift_nxt = {r_shift[5:0], w_dq[0]};
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        if ({r_shift, w_dq[0]} == CMD_QPI_ENTER) w_qpi_nxt = 1'b1;
                        w_state_nxt = StIgnore;
                    end
                end
                StQpiCmd: if (w_sclk_rise) begin
                    w_shift_nxt = {r_shift[2:0], w_dq};
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_cmd_nxt = {r_shift[3:0], w_dq};
                        w_cnt_nxt = '0;
                        if (w_cmd_nxt == CMD_QPI_WRITE || w_cmd_nxt == CMD_QPI_READ) begin
                            w_state_nxt = StAddr;
                        end else begin
                            if (w_cmd_nxt == CMD_QPI_EXIT) w_qpi_nxt = 1'b0;
                            w_state_nxt = StIgnore;
                        end
                    end
                end
                StAddr: if (w_sclk_rise) begin
                    w_addr_nxt = w_addr_shift;
                    w_cnt_nxt  = r_cnt + 4'd1;
                    if (r_cnt == 4'd5) begin
                        w_cnt_nxt = '0;
                        if (r_cmd == CMD_QPI_READ) begin
                            w_rd_en     = 1'b1;
                            w_rd_addr   = w_addr_shift;
                            w_state_nxt = StWait;
                        end else begin
                            w_state_nxt = StWrData;
                        end
                    end
                end
                StWait: if (w_sclk_rise) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == WAIT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = StRdData;
                    end
                end
                StRdData: if (w_sclk_fall) begin
                    if (!r_phase) begin
                        // Park the low nibble so the array can fetch the next byte now.
                        w_dq_nxt    = r_rdata[7:4];
                        w_hold_nxt  = r_rdata[3:0];
                        w_oe_nxt    = 1'b1;
                        w_phase_nxt = 1'b1;
                        w_rd_en     = 1'b1;
                        w_rd_addr   = w_addr_inc;
                    end else begin
                        w_dq_nxt    = r_hold;
                        w_addr_nxt  = w_addr_inc;
                        w_phase_nxt = 1'b0;
                    end
                end
                StWrData: if (w_sclk_rise) begin
                    if (!r_phase) begin
                        w_hold_nxt  = w_dq;
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_addr_nxt  = w_addr_inc;
                        w_phase_nxt = 1'b0;
                    end
                end
                StIgnore: ;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_d <= 1'b0;
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_cmd    <= '0;
            r_addr   <= '0;
            r_qpi    <= 1'b0;
            r_oe     <= 1'b0;
            r_dq     <= '0;
            r_phase  <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_sclk_d <= w_sclk;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_cmd    <= w_cmd_nxt;
            r_addr   <= w_addr_nxt;
            r_qpi    <= w_qpi_nxt;
            r_oe     <= w_oe_nxt;
            r_dq     <= w_dq_nxt;
            r_phase  <= w_phase_nxt;
            r_hold   <= w_hold_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_addr] <= {r_hold, w_dq};
        if (w_rd_en) r_rdata <= r_mem[w_rd_addr];
    end

    assign bus.o_psram_dq = r_dq;
    assign bus.o_psram_oe = r_oe;
    assign o_qpi_mode     = r_qpi;
    assign o_state        = r_state;

endmodule

// File: tb/tb_psram_qpi_target.sv
// Directed bench for psram_qpi_target: mode entry/exit, write/read, wrap, abort, reset.
module tb_psram_qpi_target;

    localparam int CLK_P = 10;
    localparam int H     = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       qpi_mode;
    logic [3:0] state;
    int         n_checks = 0;
    int         n_errors = 0;

    psram_qpi_target_if u_if ();

    psram_qpi_target #(.ADDR_BITS(10), .WAIT_CYCLES(6)) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (u_if.slave),
        .o_qpi_mode (qpi_mode),
        .o_state    (state)
    );

    always #(CLK_P / 2) clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cs_low();
        u_if.i_psram_csn = 1'b0;
        #H;
    endtask

    task automatic cs_high();
        #H;
        u_if.i_psram_csn = 1'b1;
        #(2 * H);
    endtask

    task automatic pulse_nib(input logic [3:0] n);
        u_if.i_psram_dq = n;
        #H;
        u_if.i_psram_sclk = 1'b1;
        #H;
        u_if.i_psram_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) pulse_nib({3'b000, b[i]});
    endtask

    task automatic qpi_byte(input logic [7:0] b);
        pulse_nib(b[7:4]);
        pulse_nib(b[3:0]);
    endtask

    task automatic qpi_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) pulse_nib(a[4*i +: 4]);
    endtask

    task automatic spi_cmd(input logic [7:0] op);
        cs_low();
        spi_byte(op);
        cs_high();
    endtask

    task automatic qpi_write2(input logic [23:0] a, input logic [15:0] d);
        cs_low();
        qpi_byte(8'h38);
        qpi_addr(a);
        qpi_byte(d[15:8]);
        qpi_byte(d[7:0]);
        cs_high();
    endtask

    // Issues EBh plus wait edges; leaves sclk low just after the last wait edge.
    task automatic rd_start(input string tag, input logic [23:0] a);
        cs_low();
        qpi_byte(8'hEB);
        qpi_addr(a);
        for (int i = 0; i < 6; i++) begin
            u_if.i_psram_dq = 4'h0;
            #H;
            u_if.i_psram_sclk = 1'b1;
            #(H / 2);
            check_eq({tag, "_oe_wait"}, {31'd0, u_if.o_psram_oe}, 32'd0);
            #(H / 2);
            u_if.i_psram_sclk = 1'b0;
        end
        #H;
    endtask

    task automatic rd_check(input string tag, input logic [23:0] a, input int n_nib,
                            input logic [31:0] exp);
        rd_start(tag, a);
        for (int i = 0; i < n_nib; i++) begin
            if (i > 0) begin
                u_if.i_psram_sclk = 1'b1;
                #H;
                u_if.i_psram_sclk = 1'b0;
                #H;
            end
            check_eq($sformatf("%s_nib%0d", tag, i), {28'd0, u_if.o_psram_dq},
                     {28'd0, exp[4*(n_nib-1-i) +: 4]});
        end
        check_eq({tag, "_oe_data"}, {31'd0, u_if.o_psram_oe}, 32'd1);
        cs_high();
    endtask

    initial begin
        rst_n             = 1'b0;
        u_if.i_psram_csn  = 1'b1;
        u_if.i_psram_sclk = 1'b0;
        u_if.i_psram_dq   = 4'h0;
        #22;
        check_eq("rst_state", {28'd0, state}, 32'd0);
        check_eq("rst_qpi", {31'd0, qpi_mode}, 32'd0);
        check_eq("rst_oe", {31'd0, u_if.o_psram_oe}, 32'd0);
        check_eq("rst_dq", {28'd0, u_if.o_psram_dq}, 32'd0);
        #20;
        rst_n = 1'b1;
        #(2 * H);

        spi_cmd(8'h9F);
        check_eq("spi_9f_qpi", {31'd0, qpi_mode}, 32'd0);
        spi_cmd(8'h35);
        check_eq("spi_35_qpi", {31'd0, qpi_mode}, 32'd1);

        qpi_write2(24'h000010, 16'hA53C);
        rd_check("rd010", 24'h000010, 4, 32'h0000A53C);

        qpi_write2(24'h0003FF, 16'h1122);
        rd_check("wrap000", 24'h000000, 2, 32'h00000022);
        rd_check("wrap3ff", 24'h0003FF, 4, 32'h00001122);
        rd_check("alias", 24'h400010, 2, 32'h000000A5);

        qpi_write2(24'h000020, 16'h5A00);
        cs_low();
        qpi_byte(8'h38);
        qpi_addr(24'h000020);
        pulse_nib(4'hF);
        cs_high();
        rd_check("abort_wr", 24'h000020, 2, 32'h0000005A);

        rd_start("abort_rd", 24'h000010);
        check_eq("abort_rd_oe_on", {31'd0, u_if.o_psram_oe}, 32'd1);
        u_if.i_psram_csn = 1'b1;
        #(4 * CLK_P);
        check_eq("abort_rd_oe_off", {31'd0, u_if.o_psram_oe}, 32'd0);
        #(2 * H);

        cs_low();
        qpi_byte(8'hF5);
        cs_high();
        check_eq("exit_qpi", {31'd0, qpi_mode}, 32'd0);
        spi_cmd(8'h35);
        check_eq("reenter_qpi", {31'd0, qpi_mode}, 32'd1);

        rd_start("rst_rd", 24'h000011);
        check_eq("rst_rd_nib0", {28'd0, u_if.o_psram_dq}, 32'h3);
        rst_n = 1'b0;
        #1;
        check_eq("rst_rd_oe", {31'd0, u_if.o_psram_oe}, 32'd0);
        check_eq("rst_rd_state", {28'd0, state}, 32'd0);
        check_eq("rst_rd_qpi", {31'd0, qpi_mode}, 32'd0);
        u_if.i_psram_csn = 1'b1;
        #19;
        rst_n = 1'b1;
        #(2 * H);
        spi_cmd(8'h35);
        rd_check("post_rst", 24'h000010, 4, 32'h0000A53C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
